frame_scanout: RTL and testbench

Parametrised, double-buffered framebuffer scan-out engine for the VGA path. It sits between the VGA controller (DrawX/DrawY/DrawEn) and an external synchronous framebuffer RAM holding two banks of source pixels. It upscales a SRC_W×SRC_H image by an integer SCALE and registers the RGB output through a fixed 2-cycle pipeline. It swaps front/back banks only during vertical blank, using a request/acknowledge handshake with the game logic.

---
 rtl/frame_scanout.sv | 132 +++++++++++++
 tb/tb_frame_scanout.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanout.sv
// Double-buffered framebuffer scan-out with integer upscale and vblank bank swap.
// Optional overlay path enabled by defining FB_OVERLAY_EN.
module frame_scanout #(
  parameter int          SRC_W      = 240,
  parameter int          SRC_H      = 160,
  parameter int          SCALE      = 2,
  parameter logic [23:0] BORDER_RGB = 24'h0000FF,
  parameter logic [23:0] KEY_RGB    = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        DrawEn,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [18:0] fb_raddr,
  input  logic [23:0] fb_rdata,
`ifdef FB_OVERLAY_EN
  input  logic [23:0] ov_rdata,
`endif
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        back_bank,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  localparam int          SH    = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam logic [10:0] ACT_W = 11'(SRC_W * SCALE);
  localparam logic [10:0] ACT_H = 11'(SRC_H * SCALE);
  localparam logic [18:0] BANK  = 19'(SRC_W * SRC_H);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic        front;
  logic [0:0]  state;
  logic        req_q;
  logic        act_q;
  logic        en_q;

  logic        vis;
  logic        vbl;
  logic        rise;
  logic [18:0] row;
  logic [18:0] col;
  logic [18:0] off;
  logic [18:0] base;
  logic [23:0] rgb_d;

  assign vis  = ({1'b0, DrawX} < ACT_W) && ({1'b0, DrawY} < ACT_H);
  assign vbl  = (DrawX == 10'd0) && ({1'b0, DrawY} == ACT_H);
  assign rise = swap_req & ~req_q;
  assign row  = 19'(DrawY >> SH);
  assign col  = 19'(DrawX >> SH);
  assign off  = vis ? (row * 19'(SRC_W) + col) : 19'd0;
  assign base = front ? BANK : 19'd0;

  assign back_bank = ~front;

  // Stage 0: address and flags; the flags ride alongside the RAM read
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fb_raddr <= '0;
      act_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      fb_raddr <= base + off;
      act_q    <= vis;
      en_q     <= DrawEn;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (en_q) begin
      if (!act_q) begin
        rgb_d = BORDER_RGB;
      end else begin
        rgb_d = fb_rdata;
`ifdef FB_OVERLAY_EN
        if (ov_rdata != KEY_RGB)
          rgb_d = ov_rdata;
`endif
      end
    end
  end

`ifndef FB_OVERLAY_EN
  logic unused_key;
  assign unused_key = ^KEY_RGB;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= rgb_d[23:16];
      G <= rgb_d[15:8];
      B <= rgb_d[7:0];
    end
  end

  // Swap only at vblank start; edges while pending collapse into one swap
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      front    <= 1'b0;
      req_q    <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      req_q    <= swap_req;
      swap_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (rise)
            state <= PENDING;
        end
        default: begin
          if (vbl) begin
            state    <= IDLE;
            front    <= ~front;
            swap_ack <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout: default build plus a SCALE=4 instance.
module tb_frame_scanout;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        DrawEn = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [23:0] fb_rdata = '0;
  logic        swap_req = 1'b0;
`ifdef FB_OVERLAY_EN
  logic [23:0] ov_rdata = 24'hFF00FF;
`endif

  logic [18:0] fb_raddr;
  logic        swap_ack;
  logic        back_bank;
  logic [7:0]  R, G, B;

  logic [18:0] fb_raddr4;
  logic        swap_ack4;
  logic        back_bank4;
  logic [7:0]  R4, G4, B4;

  int checks = 0;
  int errors = 0;
  int acks;

  always #5 Clk = ~Clk;

  frame_scanout u0 (
    .Clk(Clk), .Reset(Reset), .DrawEn(DrawEn),
    .DrawX(DrawX), .DrawY(DrawY),
    .fb_raddr(fb_raddr), .fb_rdata(fb_rdata),
`ifdef FB_OVERLAY_EN
    .ov_rdata(ov_rdata),
`endif
    .swap_req(swap_req), .swap_ack(swap_ack),
    .back_bank(back_bank), .R(R), .G(G), .B(B)
  );

  frame_scanout #(.SRC_W(160), .SRC_H(120), .SCALE(4)) u4 (
    .Clk(Clk), .Reset(Reset), .DrawEn(DrawEn),
    .DrawX(DrawX), .DrawY(DrawY),
    .fb_raddr(fb_raddr4), .fb_rdata(fb_rdata),
`ifdef FB_OVERLAY_EN
    .ov_rdata(ov_rdata),
`endif
    .swap_req(swap_req), .swap_ack(swap_ack4),
    .back_bank(back_bank4), .R(R4), .G(G4), .B(B4)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic px(input logic [9:0] x, input logic [9:0] y,
                    input logic en);
    DrawX  = x;
    DrawY  = y;
    DrawEn = en;
  endtask

  initial begin
    step();
    step();
    #2 Reset = 1'b0;

    // basic pixel fetch, 2-cycle latency
    px(10'd5, 10'd7, 1'b1);
    step();
    chk("raddr_5_7", 32'(fb_raddr), 32'd722);
    chk("rgb_lat1", 32'({R, G, B}), 32'h000000);
    fb_rdata = 24'h123456;
    step();
    chk("rgb_5_7", 32'({R, G, B}), 32'h123456);

    // asynchronous reset mid-line
    #2 Reset = 1'b1;
    #1;
    chk("rst_rgb", 32'({R, G, B}), 32'h0);
    chk("rst_raddr", 32'(fb_raddr), 32'd0);
    chk("rst_back", 32'(back_bank), 32'd1);
    chk("rst_ack", 32'(swap_ack), 32'd0);
    step();
    #2 Reset = 1'b0;

    // border and blank
    px(10'd480, 10'd10, 1'b1);
    step();
    chk("raddr_border", 32'(fb_raddr), 32'd0);
    step();
    chk("rgb_border", 32'({R, G, B}), 32'h0000FF);
    px(10'd480, 10'd10, 1'b0);
    step();
    step();
    chk("rgb_blank", 32'({R, G, B}), 32'h000000);

    // SCALE=4 corner and row below
    px(10'd639, 10'd479, 1'b1);
    step();
    chk("s4_raddr_corner", 32'(fb_raddr4), 32'd19199);
    chk("s4_act_corner0", 32'(fb_raddr), 32'd0);
    step();
    chk("s4_rgb_corner", 32'({R4, G4, B4}), 32'h123456);
    px(10'd5, 10'd480, 1'b1);
    step();
    step();
    chk("s4_rgb_border", 32'({R4, G4, B4}), 32'h0000FF);

    // single swap request
    px(10'd0, 10'd100, 1'b1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    chk("sw_wait_ack", 32'(swap_ack), 32'd0);
    chk("sw_wait_back", 32'(back_bank), 32'd1);
    px(10'd0, 10'd319, 1'b0);
    step();
    chk("sw_319_ack", 32'(swap_ack), 32'd0);
    px(10'd0, 10'd320, 1'b0);
    step();
    chk("sw_vbl_ack", 32'(swap_ack), 32'd1);
    chk("sw_vbl_back", 32'(back_bank), 32'd0);
    px(10'd1, 10'd320, 1'b0);
    step();
    chk("sw_ack_pulse", 32'(swap_ack), 32'd0);
    px(10'd0, 10'd0, 1'b1);
    step();
    chk("sw_bank1_raddr", 32'(fb_raddr), 32'd38400);

    // held request for 3 frames swaps once
    acks = 0;
    swap_req = 1'b1;
    for (int f = 0; f < 3; f++) begin
      px(10'd0, 10'd100, 1'b1);
      step();
      acks += int'(swap_ack);
      px(10'd0, 10'd320, 1'b0);
      step();
      acks += int'(swap_ack);
      px(10'd1, 10'd320, 1'b0);
      step();
      acks += int'(swap_ack);
    end
    swap_req = 1'b0;
    chk("hold_acks", 32'(acks), 32'd1);
    chk("hold_back", 32'(back_bank), 32'd1);

    // second edge while pending is absorbed
    px(10'd0, 10'd100, 1'b1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    px(10'd0, 10'd320, 1'b0);
    step();
    chk("abs_ack", 32'(swap_ack), 32'd1);
    chk("abs_back", 32'(back_bank), 32'd0);
    px(10'd1, 10'd320, 1'b0);
    step();
    px(10'd0, 10'd320, 1'b0);
    step();
    chk("abs_no_2nd", 32'(swap_ack), 32'd0);
    chk("abs_back2", 32'(back_bank), 32'd0);
    px(10'd1, 10'd320, 1'b0);
    step();

    // edge on the vblank-start cycle waits a frame
    px(10'd0, 10'd320, 1'b0);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("same_ack", 32'(swap_ack), 32'd0);
    chk("same_back", 32'(back_bank), 32'd0);
    px(10'd1, 10'd320, 1'b0);
    step();
    px(10'd0, 10'd320, 1'b0);
    step();
    chk("next_ack", 32'(swap_ack), 32'd1);
    chk("next_back", 32'(back_bank), 32'd1);

`ifdef FB_OVERLAY_EN
    fb_rdata = 24'h123456;
    ov_rdata = 24'hFF00FF;
    px(10'd5, 10'd7, 1'b1);
    step();
    step();
    chk("ov_key", 32'({R, G, B}), 32'h123456);
    ov_rdata = 24'h00FF00;
    step();
    chk("ov_show", 32'({R, G, B}), 32'h00FF00);
    px(10'd480, 10'd10, 1'b1);
    step();
    step();
    chk("ov_border", 32'({R, G, B}), 32'h0000FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
